sma_mc: RTL and testbench

// Multi-channel simple-moving-average filter. It is the parametrised successor of the

---
 rtl/sma_pkg.sv | 27 ++
 rtl/sma_sample_ram.sv | 41 ++++
 rtl/sma_mc.sv | 180 ++++++++++++++++++
 tb/tb_sma_mc.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sma_pkg.sv
// Shared types and width helpers for the multi-channel SMA filter.
// The channel-state struct is sized by the package defaults below; the
// top-level parameters default to the same values and must agree with them.
package sma_pkg;

    localparam int SMA_DATA_W       = 16;
    localparam int SMA_NUM_CH       = 4;
    localparam int SMA_MAX_WIN_LOG2 = 3;

    // Width of a channel id: $clog2(NUM_CH), but never narrower than one bit.
    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Width of the window-select field: $clog2(MAX_WIN_LOG2+1), minimum one bit.
    function automatic int win_w(input int max_win_log2);
        return (max_win_log2 > 0) ? $clog2(max_win_log2 + 1) : 1;
    endfunction

    // Per-channel bookkeeping: running sum, next write slot and fill level.
    typedef struct packed {
        logic [SMA_DATA_W+SMA_MAX_WIN_LOG2-1:0] sum;
        logic [SMA_MAX_WIN_LOG2-1:0]            wptr;
        logic [SMA_MAX_WIN_LOG2:0]              fill;
    } sma_ch_state_t;

endpackage

// File: rtl/sma_sample_ram.sv
// Sample history store for the SMA filter: NUM_CH windows of 2^ADDR_W samples.
// Flop array with an asynchronous read port (so the evicted sample is
// available in the same cycle it is overwritten) and a synchronous write port.
module sma_sample_ram
    import sma_pkg::*;
#(
    parameter int DATA_W = SMA_DATA_W,
    parameter int NUM_CH = SMA_NUM_CH,
    parameter int ADDR_W = SMA_MAX_WIN_LOG2
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [ch_w(NUM_CH)-1:0]   rd_ch_i,
    input  logic [ADDR_W-1:0]         rd_addr_i,
    output logic [DATA_W-1:0]         rd_data_o,
    input  logic                      we_i,
    input  logic [ch_w(NUM_CH)-1:0]   wr_ch_i,
    input  logic [ADDR_W-1:0]         wr_addr_i,
    input  logic [DATA_W-1:0]         wr_data_i
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [NUM_CH][DEPTH];

    // Write one sample per cycle; reset wipes the whole history.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int a = 0; a < DEPTH; a++) begin
                    mem_q[c][a] <= '0;
                end
            end
        end else if (we_i) begin
            mem_q[wr_ch_i][wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ch_i][rd_addr_i];

endmodule

// File: rtl/sma_mc.sv
// Multi-channel simple-moving-average filter.
// Time-multiplexed samples carry a channel id; each channel keeps its own
// window, running sum and fill level. The window is 1<<win_log2 samples,
// selectable at run time. One registered output stage with backpressure.
// Optional feature: define SMA_ROUND_EN for round-half-up averaging instead
// of plain truncation.
module sma_mc
    import sma_pkg::*;
#(
    parameter int DATA_W       = SMA_DATA_W,
    parameter int NUM_CH       = SMA_NUM_CH,
    parameter int MAX_WIN_LOG2 = SMA_MAX_WIN_LOG2
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [DATA_W-1:0]               in_data,
    input  logic [ch_w(NUM_CH)-1:0]         in_ch,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [win_w(MAX_WIN_LOG2)-1:0]  win_log2,
    input  logic                            flush,
    output logic [DATA_W-1:0]               out_data,
    output logic [ch_w(NUM_CH)-1:0]         out_ch,
    output logic                            out_valid,
    input  logic                            out_ready
);

    localparam int CH_W   = ch_w(NUM_CH);
    localparam int WIN_W  = win_w(MAX_WIN_LOG2);
    localparam int SUM_W  = DATA_W + MAX_WIN_LOG2;
    localparam int PTR_W  = MAX_WIN_LOG2;
    localparam int FILL_W = MAX_WIN_LOG2 + 1;

    sma_ch_state_t st_q [NUM_CH];
    logic [WIN_W-1:0]  win_q, win_d;
    logic [WIN_W:0]    win_ext;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;

    logic              win_chg;
    logic              clear_all;
    logic              accept;
    logic              ch_ok;
    logic              upd;
    logic [CH_W-1:0]   ch_idx;
    sma_ch_state_t     cur;
    sma_ch_state_t     st_nxt;
    logic [FILL_W-1:0] win_len;
    logic [PTR_W-1:0]  win_mask;
    logic              full_now;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] evict;
    logic [SUM_W-1:0]  sum_nxt;
    logic [FILL_W-1:0] fill_nxt;
    logic [PTR_W-1:0]  wptr_nxt;
    logic              emit;
    logic [SUM_W:0]    rnd_sum;
    logic [DATA_W-1:0] avg;

    // Clamp an out-of-range window request to the largest supported window.
    always_comb begin
        win_ext = {1'b0, win_log2};
        if (win_ext > (WIN_W+1)'(MAX_WIN_LOG2)) begin
            win_d = WIN_W'(MAX_WIN_LOG2);
        end else begin
            win_d = win_log2;
        end
    end

    assign win_chg   = (win_d != win_q);
    assign clear_all = flush | win_chg;

    assign in_ready  = ~out_valid_q | out_ready;
    assign accept    = in_valid & in_ready;
    assign ch_ok     = ({1'b0, in_ch} < (CH_W+1)'(NUM_CH));
    assign ch_idx    = ch_ok ? in_ch : '0;
    assign upd       = accept & ch_ok & ~clear_all;

    // Work out the accepted sample's effect on its channel: evict the oldest
    // sample once the window is full, advance the pointer, saturate the fill.
    always_comb begin
        cur      = st_q[ch_idx];
        win_len  = FILL_W'(1) << win_q;
        win_mask = PTR_W'(win_len - FILL_W'(1));
        full_now = (cur.fill >= win_len);
        evict    = full_now ? rd_data : '0;
        sum_nxt  = cur.sum + SUM_W'(in_data) - SUM_W'(evict);
        fill_nxt = full_now ? win_len : (cur.fill + FILL_W'(1));
        wptr_nxt = (cur.wptr + PTR_W'(1)) & win_mask;
        emit     = upd & (fill_nxt == win_len);
        st_nxt.sum  = sum_nxt;
        st_nxt.wptr = wptr_nxt;
        st_nxt.fill = fill_nxt;
    end

    // Divide by the window with a shift; the optional rounding adds half a
    // window first, one bit wider than the sum so it cannot wrap.
    always_comb begin
`ifdef SMA_ROUND_EN
        if (win_q != '0) begin
            rnd_sum = {1'b0, sum_nxt} + (SUM_W+1)'(win_len >> 1);
        end else begin
            rnd_sum = {1'b0, sum_nxt};
        end
`else
        rnd_sum = {1'b0, sum_nxt};
`endif
        avg = DATA_W'(rnd_sum >> win_q);
    end

    // Channel state: wiped by flush or a window change, otherwise updated
    // for the one channel that took a sample this cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                st_q[c] <= '0;
            end
        end else begin
            win_q <= win_d;
            if (clear_all) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    st_q[c] <= '0;
                end
            end else if (upd) begin
                st_q[ch_idx] <= st_nxt;
            end
        end
    end

    sma_sample_ram #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk       (clk),
        .rstn      (rstn),
        .rd_ch_i   (ch_idx),
        .rd_addr_i (cur.wptr),
        .rd_data_o (rd_data),
        .we_i      (upd),
        .wr_ch_i   (ch_idx),
        .wr_addr_i (cur.wptr),
        .wr_data_i (in_data)
    );

    // Output stage: hold while stalled, otherwise load a new average or go idle.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (~out_valid_q | out_ready) begin
            out_valid_d = emit;
            if (emit) begin
                out_data_d = avg;
                out_ch_d   = ch_idx;
            end
        end
    end

    // Register the output stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_sma_mc.sv
// Testbench for sma_mc: directed table of vectors, hand-written corner
// sequences and a randomized run, all compared with a queue-based model.
module tb_sma_mc;

    localparam int NUM_CH = 4;
    localparam int MAXW   = 3;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] in_data = '0;
    logic [1:0]  in_ch = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  win_log2 = '0;
    logic        flush = 1'b0;
    logic [15:0] out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready = 1'b1;

    sma_mc dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data),
        .in_ch     (in_ch),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .win_log2  (win_log2),
        .flush     (flush),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: per-channel queue of the samples in the current window.
    int unsigned hist [NUM_CH][$];
    int          mwin;
    logic        expOv;
    logic [15:0] expData;
    logic [1:0]  expCh;

    typedef struct {
        int v, ch, d, win, fl, ordy, ev, ed, ec;
    } vec_t;
    vec_t tbl [$];

`ifdef SMA_ROUND_EN
    localparam int T5 = 4;
`else
    localparam int T5 = 3;
`endif

    function automatic vec_t mk(int v, int ch, int d, int win, int fl, int ordy, int ev, int ed, int ec);
        vec_t r;
        r.v = v; r.ch = ch; r.d = d; r.win = win; r.fl = fl; r.ordy = ordy;
        r.ev = ev; r.ed = ed; r.ec = ec;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int c = 0; c < NUM_CH; c++) hist[c].delete();
        mwin    = 0;
        expOv   = 1'b0;
        expData = '0;
        expCh   = '0;
    endtask

    function automatic logic [15:0] modelAvg(int ch);
        longint s = 0;
        for (int i = 0; i < hist[ch].size(); i++) s += hist[ch][i];
`ifdef SMA_ROUND_EN
        if (mwin > 0) s += longint'(1) << (mwin - 1);
`endif
        return 16'(s >> mwin);
    endfunction

    task automatic modelStep(int v, int ch, int d, int win, int fl, int ordy);
        int  wcl = (win > MAXW) ? MAXW : win;
        bit  rdy = !expOv || (ordy != 0);
        bit  acc = (v != 0) && rdy;
        int  w   = 1 << mwin;
        if (rdy) expOv = 1'b0;
        if (fl != 0 || wcl != mwin) begin
            for (int c = 0; c < NUM_CH; c++) hist[c].delete();
        end else if (acc && ch < NUM_CH) begin
            if (hist[ch].size() == w) void'(hist[ch].pop_front());
            hist[ch].push_back(32'(d));
            if (hist[ch].size() == w) begin
                expOv   = 1'b1;
                expData = modelAvg(ch);
                expCh   = 2'(ch);
            end
        end
        mwin = wcl;
    endtask

    task automatic checkOutput();
        check("out_valid", 32'(out_valid), 32'(expOv));
        if (expOv) begin
            check("out_data", 32'(out_data), 32'(expData));
            check("out_ch", 32'(out_ch), 32'(expCh));
        end
    endtask

    // One clock of stimulus: drive, check in_ready, advance model, check outputs.
    task automatic applyStimulus(int v, int ch, int d, int win, int fl, int ordy);
        in_valid  = 1'(v);
        in_ch     = 2'(ch);
        in_data   = 16'(d);
        win_log2  = 2'(win);
        flush     = 1'(fl);
        out_ready = 1'(ordy);
        #2;
        check("in_ready", 32'(in_ready), 32'(!expOv || ordy != 0));
        modelStep(v, ch, d, win, fl, ordy);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);
        check("reset out_ch", 32'(out_ch), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);

        // Test 1: window 4 on ch0.
        tbl.push_back(mk(0, 0, 0, 2, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 4, 2, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 8, 2, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 12, 2, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 16, 2, 0, 1, 1, 10, 0));
        tbl.push_back(mk(1, 0, 20, 2, 0, 1, 1, 14, 0));
        // Test 2: flush, then interleaved channels.
        tbl.push_back(mk(0, 0, 0, 2, 1, 1, 0, 0, 0));
        for (int k = 0; k < 4; k++) begin
            tbl.push_back(mk(1, 0, 100, 2, 0, 1, (k == 3) ? 1 : 0, 100, 0));
            tbl.push_back(mk(1, 1, 200, 2, 0, 1, (k == 3) ? 1 : 0, 200, 1));
        end
        // Test 3: window 8, full-scale samples then zeros.
        tbl.push_back(mk(0, 0, 0, 3, 0, 1, 0, 0, 0));
        for (int k = 0; k < 8; k++) tbl.push_back(mk(1, 2, 'hFFFF, 3, 0, 1, (k == 7) ? 1 : 0, 'hFFFF, 2));
        tbl.push_back(mk(1, 2, 0, 3, 0, 1, 1, 'hDFFF, 2));
        tbl.push_back(mk(1, 2, 0, 3, 0, 1, 1, 'hBFFF, 2));
        tbl.push_back(mk(1, 2, 0, 3, 0, 1, 1, 'h9FFF, 2));
        // Test 5: window change 2->1 drops that cycle's sample.
        tbl.push_back(mk(0, 0, 0, 2, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 2, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 2, 2, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 9, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 3, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 4, 1, 0, 1, 1, T5, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].v, tbl[i].ch, tbl[i].d, tbl[i].win, tbl[i].fl, tbl[i].ordy);
            check($sformatf("table[%0d].valid", i), 32'(out_valid), 32'(tbl[i].ev));
            if (tbl[i].ev != 0) begin
                check($sformatf("table[%0d].data", i), 32'(out_data), 32'(tbl[i].ed));
                check($sformatf("table[%0d].ch", i), 32'(out_ch), 32'(tbl[i].ec));
            end
        end

        // Test 4: backpressure holds the output and blocks input.
        applyStimulus(1, 1, 10, 1, 0, 1);
        applyStimulus(1, 1, 20, 1, 0, 1);
        check("bp first out", 32'(out_data), 32'd15);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 1, 30, 1, 0, 0);
            check("bp in_ready low", 32'(in_ready), 32'd0);
            check("bp held data", 32'(out_data), 32'd15);
            check("bp held valid", 32'(out_valid), 32'd1);
        end
        applyStimulus(1, 1, 30, 1, 0, 1);
        check("bp release accept", 32'(out_data), 32'd25);

        // Test 6: asynchronous reset with a pending output.
        applyStimulus(1, 3, 50, 1, 0, 1);
        applyStimulus(1, 3, 60, 1, 0, 0);
        check("pre-reset valid", 32'(out_valid), 32'd1);
        rstn = 1'b0;
        #1;
        check("async reset valid", 32'(out_valid), 32'd0);
        check("async reset data", 32'(out_data), 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        applyStimulus(1, 3, 70, 1, 0, 1);
        applyStimulus(1, 3, 80, 1, 0, 1);
        check("post-reset no early out", 32'(out_valid), 32'd0);
        applyStimulus(1, 3, 90, 1, 0, 1);
        check("post-reset first out", 32'(out_data), 32'd85);

        // Randomized run against the model.
        for (int n = 0; n < 800; n++) begin
            int w = mwin;
            if ($urandom_range(0, 99) < 2) w = $urandom_range(0, 3);
            applyStimulus(($urandom_range(0, 99) < 70) ? 1 : 0,
                          $urandom_range(0, NUM_CH - 1),
                          ($urandom_range(0, 9) == 0) ? 'hFFFF : $urandom_range(0, 'hFFFF),
                          w,
                          ($urandom_range(0, 99) < 3) ? 1 : 0,
                          ($urandom_range(0, 99) < 75) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
